// File: rtl/cipher_serializer_pkg.sv
// ============================================================================
// Module  : cipher_pkg
// Brief   : Shared constants, count-width helper and FSM state encoding
//           for the XOR cipher serializer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cipher_pkg;

  // Default word width for data, key and ciphertext
  localparam int DEFAULT_DATA_SIZE = 32;

  // Bit-count width; one extra bit so the count can hold the full word size
  function automatic int cnt_width(input int size);
    return $clog2(size) + 1;
  endfunction

  // Serializer states, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cipher_serializer_if.sv
// ============================================================================
// Module  : cipher_serializer_if
// Brief   : Load-status inputs and serial/status outputs of the cipher
//           serializer. The master drives the loaded words and counts, the
//           slave (the serializer) drives the serial bit and status.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cipher_serializer_if
  import cipher_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int CNT_W     = cnt_width(DATA_SIZE)
) ();

  logic                 iEn;
  logic                 iLoading;
  logic [DATA_SIZE-1:0] iData;
  logic [DATA_SIZE-1:0] iKey;
  logic [CNT_W-1:0]     iData_count;
  logic [CNT_W-1:0]     iKey_count;
  logic                 oSerial;
  logic                 oValid;
  logic                 oBusy;
  logic                 oDone;
  logic [CNT_W-1:0]     oBit_count;

  modport master (
    output iEn, iLoading, iData, iKey, iData_count, iKey_count,
    input  oSerial, oValid, oBusy, oDone, oBit_count
  );

  modport slave (
    input  iEn, iLoading, iData, iKey, iData_count, iKey_count,
    output oSerial, oValid, oBusy, oDone, oBit_count
  );

endinterface

`default_nettype wire

// File: rtl/cipher_serializer.sv
// ============================================================================
// Module  : cipher_serializer
// Brief   : Waits for fully loaded data and key words, captures
//           data ^ key and shifts it out MSB-first, one bit per enabled
//           clock, with valid/busy/done status and a transmitted-bit count.
//           Optional macro CIPHER_PARITY_EN appends an even-parity bit after
//           the LSB (word length DATA_SIZE+1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cipher_serializer
  import cipher_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE
) (
  input  wire logic          iClk,
  input  wire logic          iRst,
  cipher_serializer_if.slave bus
);

  localparam int CNT_W = cnt_width(DATA_SIZE);

`ifdef CIPHER_PARITY_EN
  localparam int TOTAL = DATA_SIZE + 1;
`else
  localparam int TOTAL = DATA_SIZE;
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TOTAL-1:0]     r_shift;
  logic [TOTAL-1:0]     w_shift_nxt;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_nxt;

  logic [DATA_SIZE-1:0] w_cipher;
  logic [TOTAL-1:0]     w_capture;
  logic                 w_start;

  assign w_cipher = bus.iData ^ bus.iKey;

  // The parity bit rides in the LSB of the shift register so it simply
  // follows the ciphertext out without any extra output mux.
`ifdef CIPHER_PARITY_EN
  assign w_capture = {w_cipher, ^w_cipher};
`else
  assign w_capture = w_cipher;
`endif

  // Only an exact full count on both words arms a capture; any other value
  // (including over-range counts) is ignored.
  assign w_start = bus.iEn && !bus.iLoading
                && (bus.iData_count == CNT_W'(DATA_SIZE))
                && (bus.iKey_count  == CNT_W'(DATA_SIZE));

  // State, shift register and bit counter, cleared asynchronously on reset
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state logic; an abort via iLoading wins over shifting
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_count_nxt = r_count;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = SHIFT;
          w_shift_nxt = w_capture;
          w_count_nxt = '0;
        end
      end
      SHIFT: begin
        if (bus.iLoading) begin
          w_state_nxt = IDLE;
          w_shift_nxt = '0;
          w_count_nxt = '0;
        end else if (bus.iEn) begin
          w_shift_nxt = {r_shift[TOTAL-2:0], 1'b0};
          w_count_nxt = r_count + 1'b1;
          if (r_count == CNT_W'(TOTAL - 1)) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        // Parked until upstream reloads, so stale full counts cannot re-fire
        if (bus.iLoading) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_shift_nxt = '0;
        w_count_nxt = '0;
      end
    endcase
  end

  // Outputs decoded from registered state only
  assign bus.oSerial    = (r_state == SHIFT) && r_shift[TOTAL-1];
  assign bus.oValid     = (r_state == SHIFT);
  assign bus.oBusy      = (r_state == SHIFT);
  assign bus.oDone      = (r_state == DONE);
  assign bus.oBit_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_cipher_serializer.sv
// ============================================================================
// Module  : tb_cipher_serializer
// Brief   : Directed self-checking bench for cipher_serializer, DATA_SIZE=8.
//           Expectations follow CIPHER_PARITY_EN when it is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cipher_serializer;

  localparam int DATA_SIZE = 8;
  localparam int CNT_W     = 4;
`ifdef CIPHER_PARITY_EN
  localparam int TOTAL = DATA_SIZE + 1;
`else
  localparam int TOTAL = DATA_SIZE;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  cipher_serializer_if #(.DATA_SIZE(DATA_SIZE), .CNT_W(CNT_W)) bus ();

  cipher_serializer #(.DATA_SIZE(DATA_SIZE)) dut (
    .iClk (clk),
    .iRst (rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a fully loaded word pair; capture happens on the next posedge
  task automatic load_word(input logic [7:0] d, input logic [7:0] k);
    bus.iData       = d;
    bus.iKey        = k;
    bus.iData_count = CNT_W'(DATA_SIZE);
    bus.iKey_count  = CNT_W'(DATA_SIZE);
    bus.iLoading    = 1'b0;
    bus.iEn         = 1'b1;
  endtask

  // Pulse iLoading with counts cleared to return to IDLE
  task automatic rearm();
    bus.iLoading    = 1'b1;
    bus.iData_count = '0;
    bus.iKey_count  = '0;
    @(negedge clk);
    bus.iLoading    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.iEn = 1'b0; bus.iLoading = 1'b0;
    bus.iData = '0; bus.iKey = '0;
    bus.iData_count = '0; bus.iKey_count = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.oSerial, bus.oValid, bus.oBusy, bus.oDone, bus.oBit_count} !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: got %b expected 00000000",
               {bus.oSerial, bus.oValid, bus.oBusy, bus.oDone, bus.oBit_count});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [TOTAL-1:0] exp;
`ifdef CIPHER_PARITY_EN
    exp = {8'h99, 1'b0};
`else
    exp = 8'h99;
`endif
    load_word(8'hA5, 8'h3C);
    for (int i = 0; i < TOTAL; i++) begin
      @(negedge clk);
      checks++;
      if (bus.oSerial !== exp[TOTAL-1-i] || bus.oValid !== 1'b1 ||
          bus.oBusy !== 1'b1 || bus.oBit_count !== CNT_W'(i)) begin
        failures++;
        $display("FAIL basic_bit%0d: got ser=%b val=%b busy=%b cnt=%0d expected ser=%b val=1 busy=1 cnt=%0d",
                 i, bus.oSerial, bus.oValid, bus.oBusy, bus.oBit_count, exp[TOTAL-1-i], i);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.oDone !== 1'b1 || bus.oValid !== 1'b0 || bus.oBusy !== 1'b0 ||
        bus.oSerial !== 1'b0 || bus.oBit_count !== CNT_W'(TOTAL)) begin
      failures++;
      $display("FAIL basic_done: got done=%b val=%b busy=%b ser=%b cnt=%0d expected done=1 val=0 busy=0 ser=0 cnt=%0d",
               bus.oDone, bus.oValid, bus.oBusy, bus.oSerial, bus.oBit_count, TOTAL);
    end
  endtask

  // Entered in DONE with counts still full
  task automatic test_gating();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.oDone !== 1'b1 || bus.oValid !== 1'b0 || bus.oBit_count !== CNT_W'(TOTAL)) begin
        failures++;
        $display("FAIL no_refire: got done=%b val=%b cnt=%0d expected done=1 val=0 cnt=%0d",
                 bus.oDone, bus.oValid, bus.oBit_count, TOTAL);
      end
    end
    rearm();
    checks++;
    if (bus.oDone !== 1'b0 || bus.oValid !== 1'b0 || bus.oBit_count !== '0) begin
      failures++;
      $display("FAIL rearm_idle: got done=%b val=%b cnt=%0d expected done=0 val=0 cnt=0",
               bus.oDone, bus.oValid, bus.oBit_count);
    end
    load_word(8'hA5, 8'h3C);
    bus.iData_count = 4'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.oValid !== 1'b0 || bus.oBusy !== 1'b0) begin
        failures++;
        $display("FAIL short_count: got val=%b busy=%b expected val=0 busy=0", bus.oValid, bus.oBusy);
      end
    end
    bus.iData_count = 4'd8;
    bus.iKey_count  = 4'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.oValid !== 1'b0 || bus.oBusy !== 1'b0) begin
        failures++;
        $display("FAIL over_count: got val=%b busy=%b expected val=0 busy=0", bus.oValid, bus.oBusy);
      end
    end
    bus.iKey_count = 4'd8;
    bus.iEn = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.oValid !== 1'b0) begin
      failures++;
      $display("FAIL en_gate: got val=%b expected val=0", bus.oValid);
    end
    bus.iEn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.oValid !== 1'b1 || bus.oSerial !== 1'b1 || bus.oBit_count !== '0) begin
      failures++;
      $display("FAIL rearm_capture: got val=%b ser=%b cnt=%0d expected val=1 ser=1 cnt=0",
               bus.oValid, bus.oSerial, bus.oBit_count);
    end
    rearm();
  endtask

  task automatic test_stall();
    logic [TOTAL-1:0] exp;
`ifdef CIPHER_PARITY_EN
    exp = {8'h99, 1'b0};
`else
    exp = 8'h99;
`endif
    load_word(8'hA5, 8'h3C);
    for (int i = 0; i < TOTAL; i++) begin
      @(negedge clk);
      checks++;
      if (bus.oSerial !== exp[TOTAL-1-i] || bus.oBit_count !== CNT_W'(i)) begin
        failures++;
        $display("FAIL stall_bit%0d: got ser=%b cnt=%0d expected ser=%b cnt=%0d",
                 i, bus.oSerial, bus.oBit_count, exp[TOTAL-1-i], i);
      end
      if (i == 2) begin
        bus.iEn = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          checks++;
          if (bus.oSerial !== exp[TOTAL-3] || bus.oBit_count !== CNT_W'(2) || bus.oValid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold%0d: got ser=%b cnt=%0d val=%b expected ser=%b cnt=2 val=1",
                     s, bus.oSerial, bus.oBit_count, bus.oValid, exp[TOTAL-3]);
          end
        end
        bus.iEn = 1'b1;
      end
    end
    @(negedge clk);
    checks++;
    if (bus.oDone !== 1'b1 || bus.oBit_count !== CNT_W'(TOTAL)) begin
      failures++;
      $display("FAIL stall_done: got done=%b cnt=%0d expected done=1 cnt=%0d",
               bus.oDone, bus.oBit_count, TOTAL);
    end
    rearm();
  endtask

  task automatic test_abort();
    load_word(8'hA5, 8'h3C);
    repeat (5) @(negedge clk);
    checks++;
    if (bus.oBit_count !== CNT_W'(4) || bus.oValid !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre: got cnt=%0d val=%b expected cnt=4 val=1", bus.oBit_count, bus.oValid);
    end
    bus.iLoading    = 1'b1;
    bus.iData_count = '0;
    bus.iKey_count  = '0;
    @(negedge clk);
    checks++;
    if (bus.oValid !== 1'b0 || bus.oBusy !== 1'b0 || bus.oBit_count !== '0) begin
      failures++;
      $display("FAIL abort_idle: got val=%b busy=%b cnt=%0d expected val=0 busy=0 cnt=0",
               bus.oValid, bus.oBusy, bus.oBit_count);
    end
    bus.iLoading = 1'b0;
    for (int i = 0; i < TOTAL + 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.oDone !== 1'b0 || bus.oValid !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet%0d: got done=%b val=%b expected done=0 val=0", i, bus.oDone, bus.oValid);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    load_word(8'hA5, 8'h3C);
    repeat (4) @(negedge clk);
    checks++;
    if (bus.oBit_count !== CNT_W'(3) || bus.oValid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: got cnt=%0d val=%b expected cnt=3 val=1", bus.oBit_count, bus.oValid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.oSerial, bus.oValid, bus.oBusy, bus.oDone, bus.oBit_count} !== 8'h00) begin
      failures++;
      $display("FAIL rst_async: got %b expected 00000000",
               {bus.oSerial, bus.oValid, bus.oBusy, bus.oDone, bus.oBit_count});
    end
    bus.iData_count = '0;
    bus.iKey_count  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.oValid !== 1'b0 || bus.oBit_count !== '0) begin
        failures++;
        $display("FAIL rst_after%0d: got val=%b cnt=%0d expected val=0 cnt=0", i, bus.oValid, bus.oBit_count);
      end
    end
  endtask

`ifdef CIPHER_PARITY_EN
  task automatic test_parity();
    logic [TOTAL-1:0] exp;
    exp = {8'h01, 1'b1};
    load_word(8'h01, 8'h00);
    for (int i = 0; i < TOTAL; i++) begin
      @(negedge clk);
      checks++;
      if (bus.oSerial !== exp[TOTAL-1-i] || bus.oBit_count !== CNT_W'(i)) begin
        failures++;
        $display("FAIL parity_bit%0d: got ser=%b cnt=%0d expected ser=%b cnt=%0d",
                 i, bus.oSerial, bus.oBit_count, exp[TOTAL-1-i], i);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.oDone !== 1'b1 || bus.oBit_count !== CNT_W'(9)) begin
      failures++;
      $display("FAIL parity_done: got done=%b cnt=%0d expected done=1 cnt=9", bus.oDone, bus.oBit_count);
    end
    rearm();
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_gating();
    test_stall();
    test_abort();
    test_reset_mid_shift();
`ifdef CIPHER_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
